// File: rtl/rf_spi_arbiter.sv
// rf_spi_arbiter: two-port round-robin sequencer for the RF SPI engine with serial read-back.
// Define RF_INTR_PRIO_EN to let port 1 win ties while eng_intr is high.
module rf_spi_arbiter #(
  parameter int SHORT_DATA_OFS = 9,
  parameter int LONG_DATA_OFS = 17,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] mode0,
  input  logic [1:0] mode1,
  input  logic [9:0] addr0,
  input  logic [9:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  output logic [7:0] rdata,
  output logic       eng_c_en,
  output logic [1:0] eng_mode,
  output logic [9:0] eng_addr,
  output logic [7:0] eng_wdata,
  input  logic       eng_ready,
  input  logic       eng_dout,
  input  logic       eng_intr,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;
  state_t state;
  logic gnt, rr_last, hold_rr, win, prio;
  logic [7:0] timer, cnt, sr, ofs;
`ifdef RF_INTR_PRIO_EN
  assign prio = eng_intr && req0 && req1;
`else
  logic unused_intr;
  assign unused_intr = eng_intr;
  assign prio = 1'b0;
`endif
  assign win = prio ? 1'b1 : (req0 && req1) ? !rr_last : req1;
  assign ofs = eng_mode[1] ? 8'(LONG_DATA_OFS) : 8'(SHORT_DATA_OFS);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      eng_c_en <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err <= 1'b0;
      rdata <= 8'h00;
      busy <= 1'b0;
      eng_mode <= '0;
      eng_addr <= '0;
      eng_wdata <= '0;
      rr_last <= 1'b1;
      gnt <= 1'b0;
      hold_rr <= 1'b0;
      timer <= '0;
      cnt <= '0;
      sr <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if ((req0 || req1) && eng_ready) begin
          state <= LAUNCH;
          busy <= 1'b1;
          eng_c_en <= 1'b1;
          timer <= '0;
          gnt <= win;
          hold_rr <= prio;
          eng_mode <= win ? mode1 : mode0;
          eng_addr <= win ? addr1 : addr0;
          eng_wdata <= win ? wdata1 : wdata0;
        end
        // cnt holds the index of the upcoming edge counted from the eng_ready fall
        LAUNCH: if (!eng_ready) begin
          state <= BUSY;
          eng_c_en <= 1'b0;
          cnt <= 8'd2;
          timer <= '0;
        end else if (timer == 8'(TIMEOUT - 1)) begin
          state <= DONE;
          eng_c_en <= 1'b0;
          err <= 1'b1;
          ack0 <= !gnt;
          ack1 <= gnt;
        end else timer <= timer + 8'd1;
        // after eng_ready returns, wait two more cycles so the ack lands 3 cycles later
        BUSY: begin
          cnt <= cnt + {7'd0, cnt != 8'hFF};
          if (!eng_mode[0] && cnt >= ofs && cnt < ofs + 8'd8) sr <= {sr[6:0], eng_dout};
          if (!eng_ready) timer <= '0;
          else if (timer == 8'd2) begin
            state <= DONE;
            err <= 1'b0;
            ack0 <= !gnt;
            ack1 <= gnt;
            if (!eng_mode[0]) rdata <= sr;
          end else timer <= timer + 8'd1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          if (!hold_rr) rr_last <= gnt;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_spi_arbiter.sv
// tb_rf_spi_arbiter: directed scoreboard bench with a behavioural SPI engine model.
module tb_rf_spi_arbiter;
  logic clk = 1'b0, rst, req0, req1, eng_ready, eng_dout, eng_intr;
  logic [1:0] mode0, mode1, eng_mode;
  logic [9:0] addr0, addr1, eng_addr;
  logic [7:0] wdata0, wdata1, rdata, eng_wdata;
  logic ack0, ack1, err, eng_c_en, busy;
  typedef struct {bit port; bit err; logic [7:0] rdata;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] eng_q[$];
  bit eng_on;
  int checks = 0, errors = 0;
  int n, n0, n1;

  always #5 clk = !clk;

  rf_spi_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .ack0(ack0), .ack1(ack1),
    .err(err), .rdata(rdata), .eng_c_en(eng_c_en), .eng_mode(eng_mode), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_ready(eng_ready), .eng_dout(eng_dout), .eng_intr(eng_intr), .busy(busy)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input logic lvl);
    int i;
    for (i = 0; i < 100 && eng_ready !== lvl; i++) @(negedge clk);
    if (eng_ready !== lvl) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: eng_ready=%b, wanted %b within 100 cycles", eng_ready, lvl);
    end
  endtask

  task automatic issue(input bit p, input logic [1:0] m, input logic [9:0] a, input logic [7:0] w,
                       input bit chk, output int cen);
    bit seen, done;
    @(negedge clk);
    if (p) begin req1 = 1; mode1 = m; addr1 = a; wdata1 = w; end
    else begin req0 = 1; mode0 = m; addr0 = a; wdata0 = w; end
    cen = 0;
    seen = 0;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (eng_c_en) begin
        cen++;
        if (chk && !seen) check("latch", {eng_mode, eng_addr, eng_wdata}, {m, a, w});
        seen = 1;
      end
      if (p ? ack1 : ack0) begin
        done = 1;
        check("cen_at_ack", eng_c_en, 0);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: port %0d got no ack within 300 cycles", p);
    end
    if (p) req1 = 0; else req0 = 0;
  endtask

  // engine model: launches on eng_c_en, read bit i is valid at edge OFS+i after the ready fall
  initial begin : engine
    int bi, ofs;
    bit rd;
    logic [7:0] d;
    eng_ready = 1;
    eng_dout = 1;
    forever begin
      @(negedge clk);
      if (eng_on && eng_c_en && eng_ready) begin
        rd = !eng_mode[0];
        ofs = eng_mode[1] ? 17 : 9;
        d = 8'hFF;
        if (rd && eng_q.size() > 0) d = eng_q.pop_front();
        @(posedge clk);
        #1 eng_ready = 0;
        for (int k = 1; k <= 30; k++) begin
          @(posedge clk);
          #1;
          bi = k + 1 - ofs;
          eng_dout = (rd && bi >= 0 && bi < 8) ? d[7-bi] : 1'b1;
        end
        eng_ready = 1;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack0=%b ack1=%b err=%b rdata=%h with nothing expected", ack0, ack1, err, rdata);
        end else begin
          e = sb.pop_front();
          check("ack", {ack1, ack0, err, rdata}, {e.port, !e.port, e.err, e.rdata});
        end
        @(negedge clk);
        check("idle_gap", busy, 0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 0; req0 = 0; req1 = 0; eng_intr = 0; eng_on = 1;
    mode0 = 0; mode1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    check("reset", {ack0, ack1, err, busy, eng_c_en, rdata, eng_mode, eng_addr, eng_wdata}, 0);
    rst = 1;
    eng_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    sb.push_back('{0, 0, 8'h11});
    sb.push_back('{1, 0, 8'h22});
    sb.push_back('{0, 0, 8'h33});
    sb.push_back('{1, 0, 8'h44});
    fork
      begin issue(0, 2'b00, 10'h005, 8'h00, 0, n0); issue(0, 2'b00, 10'h006, 8'h00, 0, n0); end
      begin issue(1, 2'b00, 10'h021, 8'h00, 0, n1); issue(1, 2'b00, 10'h022, 8'h00, 0, n1); end
    join
    sb.push_back('{0, 0, 8'h44});
    issue(0, 2'b01, 10'h012, 8'hA5, 1, n);
    eng_q.push_back(8'h3C);
    sb.push_back('{1, 0, 8'h3C});
    issue(1, 2'b10, 10'h3FF, 8'h00, 1, n);
    sb.push_back('{1, 0, 8'h3C});
    issue(1, 2'b01, 10'h03F, 8'hC3, 1, n);
    eng_on = 0;
    sb.push_back('{0, 1, 8'h3C});
    issue(0, 2'b00, 10'h015, 8'h00, 1, n);
    check("timeout_cen", n, 64);
    eng_on = 1;
    @(negedge clk);
    req0 = 1; mode0 = 2'b11; addr0 = 10'h2C5; wdata0 = 8'h5A;
    wait_ready(0);
    repeat (5) @(negedge clk);
    rst = 0;
    req0 = 0;
    @(negedge clk);
    check("rst_mid", {busy, eng_c_en, ack0, ack1, rdata}, 0);
    rst = 1;
    wait_ready(1);
    sb.push_back('{0, 0, 8'h00});
    issue(0, 2'b11, 10'h2C5, 8'h5A, 1, n);
    eng_intr = 1;
`ifdef RF_INTR_PRIO_EN
    sb.push_back('{1, 0, 8'h00});
    sb.push_back('{1, 0, 8'h00});
    sb.push_back('{0, 0, 8'h00});
`else
    sb.push_back('{1, 0, 8'h00});
    sb.push_back('{0, 0, 8'h00});
    sb.push_back('{1, 0, 8'h00});
`endif
    fork
      begin issue(1, 2'b01, 10'h001, 8'h01, 0, n1); issue(1, 2'b01, 10'h002, 8'h02, 0, n1); end
      issue(0, 2'b01, 10'h003, 8'h03, 0, n0);
    join
    eng_intr = 0;
    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_spi_arbiter.md
Name: rf_spi_arbiter

Overview:
- Sequences the RF SPI register-access engine and shares it between two requesters: port 0 (MAC/host datapath) and port 1 (interrupt service logic).
- Arbitrates pending requests, launches one engine transaction at a time, and tracks completion via the engine's ready/c_en handshake.
- Deserialises read data from the engine's serial data output and returns a byte plus a one-cycle ack to the winning requester.

Parameters:
- SHORT_DATA_OFS, 9, rising clk edges after eng_ready falls to the first read-data bit of a short read.
- LONG_DATA_OFS, 17, rising clk edges after eng_ready falls to the first read-data bit of a long read.
- TIMEOUT, 64, max cycles in LAUNCH waiting for eng_ready to fall before an error ack.

Ports:
- clk  in  1  system clock; also the SPI bit clock.
- rst  in  1  synchronous reset, active-low.
- req0 / req1  in  1  request; held until the matching ack.
- mode0 / mode1  in  2  00 short rd, 01 short wr, 10 long rd, 11 long wr.
- addr0 / addr1  in  10  register address (short ops use [5:0]).
- wdata0 / wdata1  in  8  write data.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err  out  1  valid with an ack; 1 means timeout.
- rdata  out  8  read byte, valid with an ack; held until the next ack.
- eng_c_en  out  1  engine launch enable.
- eng_mode  out  2  to engine mode.
- eng_addr  out  10  to engine addr_in.
- eng_wdata  out  8  to engine data_in.
- eng_ready  in  1  engine ready.
- eng_dout  in  1  engine serial read data (MSB first).
- eng_intr  in  1  radio interrupt passthrough from engine.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst==0 at a rising clk): state=IDLE; eng_c_en=0, ack0=ack1=0, err=0, rdata=8'h00, busy=0, eng_mode/addr/wdata=0, rr_last=1 (port 0 wins the first tie).
- States:
  - IDLE: if any req is high and eng_ready==1, select the winner and latch its mode/addr/wdata into the eng_* regs. Go to LAUNCH next cycle.
  - LAUNCH: eng_c_en=1 and a timer counts. When eng_ready==0: eng_c_en=0, clear the bit counter, go to BUSY. If the timer reaches TIMEOUT: eng_c_en=0, go to DONE with err=1.
  - BUSY: eng_c_en=0 and a cycle counter runs from the eng_ready fall. For reads, at offsets OFS..OFS+7, shift eng_dout into a shift register (first bit is MSB). OFS is SHORT_DATA_OFS for mode 00 and LONG_DATA_OFS for mode 10. When eng_ready returns to 1, go to DONE.
  - DONE: one-cycle ack to the granted port; err as set. For reads, rdata = shift register; for writes, rdata is unchanged. Update rr_last = granted port. Go to IDLE.
- Arbitration:
  - Round-robin: on simultaneous requests, the port != rr_last wins; a lone request always wins.
  - Grant is decided only in IDLE and never changes mid-transaction.
- Latency: an uncontended request acks no earlier than 3 cycles after eng_ready returns high from its transaction's busy period. Back-to-back requests incur at least 1 IDLE cycle between transactions.
- eng_c_en is never high in BUSY, so the engine cannot relaunch on a held level.
- Requester rules:
  - req and its fields must stay stable until ack.
  - Deasserting req before ack is illegal: the transaction completes, the ack is still issued, and the request is not retracted.
  - req high in the ack cycle counts as a new request.
- A mode change on a non-granted port mid-transaction has no effect.
- Reset asserted mid-transaction: synchronous return to IDLE, eng_c_en=0, no ack or err issued; the requester must re-request.

Optional Feature:
- RF_INTR_PRIO_EN defined: while eng_intr==1, port 1 wins any tie in IDLE regardless of rr_last, and rr_last is not updated for that grant. An in-flight port 0 transaction still completes first.
- Not defined: pure round-robin, and eng_intr is unused.

Test Plan:
- Short write, port 0: req0=1, mode0=01, addr0=10'h012, wdata0=8'hA5 -> eng_mode=01, eng_addr=012, eng_wdata=A5 latched. eng_c_en high one or more cycles until eng_ready falls. Exactly one ack0 with err=0; rdata unchanged.
- Long read, port 1: engine model returns 8'h3C serially from LONG_DATA_OFS -> ack1 pulse, rdata=8'h3C, err=0. No ack0 pulses.
- Contention: req0 and req1 asserted together from reset, each issuing 2 short reads -> grant order 0,1,0,1. 4 acks total, at least 1 IDLE cycle between transactions.
- Timeout: eng_ready held at 1 after launch -> after TIMEOUT (64) cycles, eng_c_en=0 and ack0 with err=1; busy drops next cycle.
- Reset mid-BUSY during a long write: rst=0 for one cycle -> next cycle state IDLE, eng_c_en=0, busy=0, no ack. A re-request completes normally.
- With RF_INTR_PRIO_EN, eng_intr=1, rr_last=0, both ports requesting -> port 1 granted twice in a row. Without the macro -> ports alternate.
